// File: rtl/keypad_scanner_4x4.sv
// rtl/keypad_scanner_4x4.sv - 4x4 key matrix column scanner with scan-level debounce
// Drives one column low at a time, samples synchronised rows, commits stable scans.
module keypad_scanner_4x4 #(
  parameter int CLK_DIV        = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rows_in,
  output logic [3:0]  cols_out,
  output logic [15:0] keys_out,
  output logic        key_valid,
  output logic        key_event
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_t;

  col_state_t     state, state_next;
  logic [DW-1:0]  div, div_next;
  logic           tick;
  logic [3:0]     sync1, sync2;
  logic [15:0]    raw, raw_next;
  logic [15:0]    prev;
  logic [3:0]     cnt, cnt_upd;
  logic           scan_done;
  logic           commit;

  assign cols_out = ~(4'b0001 << state);

  always_comb begin
    tick       = (div == DW'(CLK_DIV - 1));
    div_next   = tick ? '0 : div + DW'(1);
    state_next = state;
    raw_next   = raw;
    scan_done  = 1'b0;
    cnt_upd    = cnt;
    commit     = 1'b0;
    if (tick) begin
      state_next = col_state_t'(state + 2'd1);
      for (int r = 0; r < 4; r++) begin
        raw_next[r*4 + int'(state)] = ~sync2[r];
      end
      scan_done = (state == COL3);
    end
    // raw_next already carries the column-3 sample, so it is the complete scan
    if (scan_done) begin
      if (raw_next == prev) begin
        cnt_upd = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;
      end else begin
        cnt_upd = 4'd1;
      end
      commit = (cnt_upd >= 4'(DEBOUNCE_SCANS)) && (raw_next != keys_out);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COL0;
      div       <= '0;
      sync1     <= 4'b1111;
      sync2     <= 4'b1111;
      raw       <= '0;
      prev      <= '0;
      cnt       <= '0;
      keys_out  <= '0;
      key_valid <= 1'b0;
      key_event <= 1'b0;
    end else begin
      state     <= state_next;
      div       <= div_next;
      sync1     <= rows_in;
      sync2     <= sync1;
      raw       <= raw_next;
      key_event <= commit;
      if (scan_done) begin
        prev <= raw_next;
        cnt  <= cnt_upd;
      end
      if (commit) begin
        keys_out  <= raw_next;
        key_valid <= |raw_next;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// tb/tb_keypad_scanner_4x4.sv - directed scoreboard bench for keypad_scanner_4x4
// A key-matrix model drives rows_in from cols_out; expected commits are queued per stimulus.
module tb_keypad_scanner_4x4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rows_in;
  logic [3:0]  cols_out;
  logic [15:0] keys_out;
  logic        key_valid;
  logic        key_event;

  logic [15:0] pressed;

  typedef struct {
    logic [15:0] keys;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  int          ev_cnt;
  int          ev_at;
  logic [15:0] ev_keys;
  logic        ev_valid;
  int          walk_bad;

  keypad_scanner_4x4 #(.CLK_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .rows_in   (rows_in),
    .cols_out  (cols_out),
    .keys_out  (keys_out),
    .key_valid (key_valid),
    .key_event (key_event)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven low
  always_comb begin
    rows_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4 + c] && !cols_out[c]) rows_in[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // Runs n edges, sampling 1 time unit after each; records key_event activity
  task automatic run_cycles(input int n);
    ev_cnt   = 0;
    ev_at    = -1;
    ev_keys  = 16'hxxxx;
    ev_valid = 1'bx;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (key_event === 1'b1) begin
        ev_cnt++;
        if (ev_at < 0) begin
          ev_at    = i;
          ev_keys  = keys_out;
          ev_valid = key_valid;
        end
      end
    end
  endtask

  task automatic expect_commit(input string name);
    exp_t e;
    run_cycles(64);
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_event_count"}, ev_cnt, 1);
      check({name, "_event_cycle"}, ev_at, e.lat);
      check({name, "_keys"}, {16'h0, ev_keys}, {16'h0, e.keys});
      check({name, "_valid"}, {31'h0, ev_valid}, {31'h0, |e.keys});
      check({name, "_keys_hold"}, {16'h0, keys_out}, {16'h0, e.keys});
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    pressed = 16'h0000;
    do_reset(2);

    // reset state
    check("rst_cols", {28'h0, cols_out}, {28'h0, 4'b1110});
    check("rst_keys", {16'h0, keys_out}, 32'h0);
    check("rst_valid", {31'h0, key_valid}, 32'h0);
    check("rst_event", {31'h0, key_event}, 32'h0);

    // column walk: 2 full scans, no key
    walk_bad = 0;
    ev_cnt   = 0;
    for (int i = 1; i <= 32; i++) begin
      logic [3:0] want;
      @(posedge clk);
      #1;
      want = ~(4'b0001 << ((i / 4) % 4));
      if (cols_out !== want) walk_bad++;
      if (key_event === 1'b1) ev_cnt++;
    end
    check("walk_cols_errors", walk_bad, 0);
    check("walk_no_event", ev_cnt, 0);
    check("walk_keys", {16'h0, keys_out}, 32'h0);

    // single key row1/col2 held from reset release
    do_reset(1);
    pressed = 16'h0040;
    exp_q.push_back('{keys: 16'h0040, lat: 48});
    expect_commit("single");

    // release
    pressed = 16'h0000;
    exp_q.push_back('{keys: 16'h0000, lat: 48});
    expect_commit("release");

    // bounce on alternate scans
    begin
      int bounce_ev = 0;
      for (int s = 0; s < 6; s++) begin
        pressed = (s % 2 == 0) ? 16'h0040 : 16'h0000;
        run_cycles(16);
        bounce_ev += ev_cnt;
      end
      check("bounce_no_event", bounce_ev, 0);
      check("bounce_keys", {16'h0, keys_out}, 32'h0);
    end
    pressed = 16'h0040;
    exp_q.push_back('{keys: 16'h0040, lat: 48});
    expect_commit("bounce_settle");

    // multi-key
    pressed = 16'h8001;
    exp_q.push_back('{keys: 16'h8001, lat: 48});
    expect_commit("multi_a");
    pressed = 16'h8021;
    exp_q.push_back('{keys: 16'h8021, lat: 48});
    expect_commit("multi_b");

    // stable scan equal to keys_out: no event
    run_cycles(64);
    check("stable_no_event", ev_cnt, 0);

    // reset mid-scan with key held
    pressed = 16'h0040;
    exp_q.push_back('{keys: 16'h0040, lat: 48});
    expect_commit("pre_reset");
    run_cycles(7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_cols", {28'h0, cols_out}, {28'h0, 4'b1110});
    check("midrst_keys", {16'h0, keys_out}, 32'h0);
    check("midrst_valid", {31'h0, key_valid}, 32'h0);
    check("midrst_event", {31'h0, key_event}, 32'h0);
    rst = 1'b0;
    exp_q.push_back('{keys: 16'h0040, lat: 48});
    expect_commit("recommit");

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
